// File: rtl/cpu_sequencer_pkg.sv
// Shared decoder state codes, opcodes and sequencer limits for the CPU
// control loop.
package cpu_sequencer_pkg;

  localparam logic [3:0] STATE_FETCH_PC   = 4'h0;
  localparam logic [3:0] STATE_FETCH_INST = 4'h1;
  localparam logic [3:0] STATE_LOAD_ADDR  = 4'h2;
  localparam logic [3:0] STATE_FETCH_MEM  = 4'h3;
  localparam logic [3:0] STATE_LOAD_A     = 4'h4;
  localparam logic [3:0] STATE_ADD        = 4'h5;
  localparam logic [3:0] STATE_STORE      = 4'h6;
  localparam logic [3:0] STATE_JUMP       = 4'h7;
  localparam logic [3:0] STATE_OUT        = 4'h8;
  localparam logic [3:0] STATE_HALT       = 4'h9;
  localparam logic [3:0] STATE_NEXT       = 4'hA;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // First micro-cycle the decoder has no entry for.
  localparam int DEFAULT_MAX_CYCLE = 7;

endpackage

// File: rtl/cpu_sequencer_step_edge_gen.sv
// Turns the run level and the debounced step level into a one-clock
// advance enable for the sequencer.
module step_edge_gen (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic step,
  input  logic halted,
  output logic adv
);

  logic step_q;

  // step_q tracks step even in run mode, so a step held across a drop of
  // run back to single-step does not produce a second advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign adv = ~halted & (run | (step & ~step_q));

endmodule

// File: rtl/cpu_sequencer.sv
// Micro-cycle sequencer: feeds cycle/opcode to the control decoder, reacts
// to its decoded state, and reports halt, fault and retired instructions.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int CYCLE_W   = 4,
  parameter int MAX_CYCLE = DEFAULT_MAX_CYCLE,
  parameter int COUNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         state,
  input  logic [7:0]         instr_in,
  input  logic               run,
  input  logic               step,
  output logic [CYCLE_W-1:0] cycle,
  output logic [3:0]         opcode,
  output logic               halted,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  logic adv;
  logic unused_operand;

  assign unused_operand = ^instr_in[3:0];

  step_edge_gen u_step_edge_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .step    (step),
    .halted  (halted),
    .adv     (adv)
  );

  // The overrun check outranks every decoded state so cycle can never
  // run past the decoder's table.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle       <= '0;
      opcode      <= 4'h0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
    end else if (adv) begin
      if (cycle >= CYCLE_W'(MAX_CYCLE)) begin
        fault  <= 1'b1;
        halted <= 1'b1;
      end else if (state == STATE_HALT) begin
        halted <= 1'b1;
      end else if (state == STATE_NEXT) begin
        cycle       <= '0;
        instr_count <= instr_count + COUNT_W'(1);
      end else begin
        cycle <= cycle + CYCLE_W'(1);
      end
      if (state == STATE_FETCH_INST) begin
        opcode <= instr_in[7:4];
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with a small control-decoder model
// closing the loop from cycle/opcode back to state.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] state;
  logic [7:0] instr_in;
  logic       run;
  logic       step;
  logic [3:0] cycle;
  logic [3:0] opcode;
  logic       halted;
  logic       fault;
  logic [7:0] instr_count;

  logic       force_en;
  logic [3:0] forced_state;

  int checks;
  int errors;

  cpu_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .state       (state),
    .instr_in    (instr_in),
    .run         (run),
    .step        (step),
    .cycle       (cycle),
    .opcode      (opcode),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] decode(input logic [3:0] c, input logic [3:0] op);
    case (c)
      4'd0:    return STATE_FETCH_PC;
      4'd1:    return STATE_FETCH_INST;
      4'd2:    return (op == OP_HLT) ? STATE_HALT : STATE_LOAD_ADDR;
      4'd3:    return STATE_FETCH_MEM;
      4'd4:    return STATE_LOAD_A;
      default: return STATE_NEXT;
    endcase
  endfunction

  always_comb begin
    state = decode(cycle, opcode);
    if (force_en) state = forced_state;
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic [7:0] instr);
    run      = r;
    step     = s;
    instr_in = instr;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    force_en     = 1'b0;
    forced_state = STATE_FETCH_PC;
    reset_n      = 1'b0;
    apply_stimulus(1'b0, 1'b0, 8'h00);
    tick(2);
    check_output("reset_cycle", 32'(cycle), 0);
    check_output("reset_count", 32'(instr_count), 0);
    reset_n = 1'b1;
    tick(2);
    check_output("idle_cycle", 32'(cycle), 0);

    // LDA with the decoder model in the loop
    apply_stimulus(1'b1, 1'b0, 8'h1A);
    tick(1);
    check_output("lda_c1", 32'(cycle), 1);
    check_output("lda_op_c1", 32'(opcode), 0);
    tick(1);
    check_output("lda_c2", 32'(cycle), 2);
    check_output("lda_op_c2", 32'(opcode), 1);
    tick(1);
    check_output("lda_c3", 32'(cycle), 3);
    tick(1);
    check_output("lda_c4", 32'(cycle), 4);
    tick(1);
    check_output("lda_c5", 32'(cycle), 5);
    check_output("lda_cnt_c5", 32'(instr_count), 0);
    tick(1);
    apply_stimulus(1'b0, 1'b0, 8'h1A);
    check_output("lda_c0", 32'(cycle), 0);
    check_output("lda_cnt", 32'(instr_count), 1);
    check_output("lda_op_held", 32'(opcode), 1);

    // Asynchronous reset in the middle of the second instruction
    apply_stimulus(1'b1, 1'b0, 8'h1A);
    tick(4);
    check_output("mid_c4", 32'(cycle), 4);
    #2 reset_n = 1'b0;
    #1;
    check_output("arst_cycle", 32'(cycle), 0);
    check_output("arst_opcode", 32'(opcode), 0);
    check_output("arst_halted", 32'(halted), 0);
    check_output("arst_fault", 32'(fault), 0);
    check_output("arst_count", 32'(instr_count), 0);
    apply_stimulus(1'b0, 1'b0, 8'h1A);
    tick(2);
    reset_n = 1'b1;
    tick(1);

    // Single step: each 5-clock pulse advances exactly once
    for (int p = 1; p <= 3; p++) begin
      apply_stimulus(1'b0, 1'b1, 8'h1A);
      tick(5);
      apply_stimulus(1'b0, 1'b0, 8'h1A);
      tick(3);
      check_output($sformatf("step_pulse%0d", p), 32'(cycle), p);
    end
    check_output("step_opcode", 32'(opcode), 1);
    apply_stimulus(1'b1, 1'b1, 8'h1A);
    tick(1);
    apply_stimulus(1'b0, 1'b1, 8'h1A);
    tick(3);
    check_output("step_in_run", 32'(cycle), 4);
    apply_stimulus(1'b0, 1'b0, 8'h1A);
    tick(2);
    check_output("step_release", 32'(cycle), 4);

    // HLT freezes at cycle 2
    do_reset();
    apply_stimulus(1'b1, 1'b0, 8'hF0);
    tick(2);
    check_output("hlt_c2", 32'(cycle), 2);
    check_output("hlt_op", 32'(opcode), 15);
    check_output("hlt_not_yet", 32'(halted), 0);
    tick(1);
    check_output("hlt_halted", 32'(halted), 1);
    check_output("hlt_cycle", 32'(cycle), 2);
    check_output("hlt_fault", 32'(fault), 0);
    apply_stimulus(1'b0, 1'b1, 8'h20);
    tick(2);
    apply_stimulus(1'b1, 1'b0, 8'h20);
    tick(2);
    apply_stimulus(1'b0, 1'b1, 8'h20);
    tick(2);
    apply_stimulus(1'b0, 1'b0, 8'h20);
    tick(1);
    check_output("hlt_frozen_cycle", 32'(cycle), 2);
    check_output("hlt_frozen_op", 32'(opcode), 15);
    check_output("hlt_frozen_halt", 32'(halted), 1);

    // Overrun, with STATE_NEXT at the limit taking the fault path
    do_reset();
    force_en     = 1'b1;
    forced_state = STATE_FETCH_PC;
    apply_stimulus(1'b1, 1'b0, 8'h00);
    tick(7);
    check_output("ovr_c7", 32'(cycle), 7);
    check_output("ovr_nofault", 32'(fault), 0);
    forced_state = STATE_NEXT;
    tick(1);
    check_output("ovr_fault", 32'(fault), 1);
    check_output("ovr_halted", 32'(halted), 1);
    check_output("ovr_cycle", 32'(cycle), 7);
    check_output("ovr_count", 32'(instr_count), 0);
    tick(2);
    check_output("ovr_hold", 32'(cycle), 7);

    // Retired-instruction counter wraps after 256 NEXT advances
    apply_stimulus(1'b0, 1'b0, 8'h00);
    do_reset();
    forced_state = STATE_NEXT;
    apply_stimulus(1'b1, 1'b0, 8'h00);
    tick(255);
    check_output("wrap_255", 32'(instr_count), 255);
    tick(1);
    check_output("wrap_0", 32'(instr_count), 0);
    check_output("wrap_fault", 32'(fault), 0);
    check_output("wrap_cycle", 32'(cycle), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Drives the cycle and opcode inputs of the CPU control decoder and consumes its decoded state, closing the control loop.
- Owns the micro-cycle counter and the opcode latch (captured during instruction fetch).
- Provides halt/fault status, a retired-instruction counter, and run/single-step gating for the front-panel clock.
- Sits between the control decoder and the datapath.

Parameters:
- CYCLE_W, 4, width of the micro-cycle counter; must match the decoder cycle input.
- MAX_CYCLE, 7, first cycle value the decoder does not decode; reaching it is a fault.
- COUNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- state  input  4  decoded state from the control decoder (STATE_* codes).
- instr_in  input  8  instruction byte from memory bus; opcode is bits [7:4].
- run  input  1  1 = free-run, 0 = single-step mode; synchronous level.
- step  input  1  single-step request; synchronous, debounced level.
- cycle  output  CYCLE_W  current micro-cycle, to the decoder.
- opcode  output  4  latched opcode, to the decoder.
- halted  output  1  sticky; the sequencer is frozen.
- fault  output  1  sticky; cycle overrun detected.
- instr_count  output  COUNT_W  number of retired instructions.

Behaviour:
- Reset (async, reset_n=0): cycle=0, opcode=4'h0, halted=0, fault=0, instr_count=0, step edge register=0. Reset mid-instruction discards the instruction; no partial state survives.
- Advance enable, adv:
  - run=1: adv=1 every clock.
  - run=0: adv=1 for exactly one clock per rising edge of step (step registered internally; adv = step & ~step_q).
  - Step edges while run=1 are ignored; they never cause a double advance.
  - step held high produces exactly one advance.
- When halted=1, adv is forced to 0. Nothing changes until reset.
- On each clock with adv=1, evaluated in this priority order:
  1. cycle >= MAX_CYCLE: fault<=1, halted<=1, cycle held.
  2. state==STATE_HALT: halted<=1, cycle held.
  3. state==STATE_NEXT: cycle<=0; instr_count<=instr_count+1, wrapping from all-ones to 0.
  4. Otherwise: cycle<=cycle+1.
- Opcode latch: on an adv clock with state==STATE_FETCH_INST, opcode<=instr_in[7:4].
  - Capture happens in the same edge as the cycle increment.
  - opcode is valid from cycle 2 onward; it is otherwise held.
- Latency: a state presented in cycle N takes effect at the next adv edge. Outputs are registered with no combinational path from state to cycle or opcode.
- The control decoder is combinational on cycle; this block is its only source of cycle. The cycle value never wraps through 15 because of the MAX_CYCLE fault check.
- State codes other than those listed above take the increment path.
- Simultaneous events: HALT and fault on the same edge yields fault=1 and halted=1. STATE_NEXT with cycle>=MAX_CYCLE takes the fault path (no count increment).

Decomposition:
- STATE_* and OP_* codes stay in the shared parameters include. Add a constant for the default MAX_CYCLE there.
- One natural sub-module, step_edge_gen (run/step to adv pulse, ~25 lines). Counter and latch stay inline.

Test Plan:
- Reset: hold reset_n=0 mid-run at cycle=4 -> cycle=0, opcode=0, halted=0, fault=0, instr_count=0 immediately, without waiting for a clock edge.
- LDA instruction (run=1, decoder model in loop):
  - Stimulus: instr_in=8'h1A during STATE_FETCH_INST.
  - Required: cycle steps 0,1,2,3,4,5; opcode=1 from cycle 2; STATE_NEXT at cycle 5 returns cycle to 0; instr_count=1.
- HLT: opcode=HLT, STATE_HALT at cycle 2 -> cycle stays 2 and halted=1 from the next edge; later run toggles and step pulses change nothing.
- Single step: run=0, three step pulses each 5 clocks high -> cycle advances exactly 0->3; a pulse asserted while run=1 adds no extra advance.
- Overrun: state forced to STATE_FETCH_PC forever -> cycle counts to 7; next edge fault=1, halted=1, cycle holds at 7.
- Wrap: 256 consecutive STATE_NEXT advances -> instr_count returns to 0, with no fault.
